// File: rtl/pipe_ctrl_pkg.sv
// Shared constants and state type for the pipeline hazard controller.
// Forward-select encodings, watchdog FSM states and default address width.
package pipe_ctrl_pkg;

   localparam int RA_W_DEF = 5;

   localparam logic [1:0] FWD_RF      = 2'b00;
   localparam logic [1:0] FWD_EXE_ALU = 2'b01;
   localparam logic [1:0] FWD_MEM_ALU = 2'b10;
   localparam logic [1:0] FWD_MEM_LW  = 2'b11;

   typedef enum logic [1:0] {
      RUN,
      MEM_WAIT,
      ERR
   } hz_state_t;

endpackage

// File: rtl/fwd_sel.sv
// Forward-priority select for one decode source operand.
// EXE ALU result beats MEM ALU result, which beats MEM load data.
module fwd_sel
   import pipe_ctrl_pkg::*;
#(
   parameter int RA_W = RA_W_DEF
) (
   input  logic [RA_W-1:0] src,
   input  logic            use_src,
   input  logic            ewreg,
   input  logic            em2reg,
   input  logic [RA_W-1:0] ern,
   input  logic            mwreg,
   input  logic            mm2reg,
   input  logic [RA_W-1:0] mrn,
   output logic [1:0]      sel
);

   logic hit;
   logic e_hit;
   logic m_hit;

   // r0 is hardwired zero, so a match on it never forwards
   assign hit   = use_src & (src != '0);
   assign e_hit = ewreg & ~em2reg & (ern == src);
   assign m_hit = mwreg & (mrn == src);

   always_comb begin
      sel = FWD_RF;
      if (hit && e_hit) begin
         sel = FWD_EXE_ALU;
      end else if (hit && m_hit && !mm2reg) begin
         sel = FWD_MEM_ALU;
      end else if (hit && m_hit) begin
         sel = FWD_MEM_LW;
      end
   end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Forwarding, load-use stall, mem-wait freeze, branch squash and watchdog.
// Define HAZ_STATS_EN to build the saturating stall/squash statistics counters.
module pipe_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int RA_W     = RA_W_DEF,
   parameter int WAIT_MAX = 15,
   parameter int WAIT_W   = 4,
   parameter int CNT_W    = 16
) (
   input  logic             clock,
   input  logic             resetn,
   input  logic [RA_W-1:0]  rs,
   input  logic [RA_W-1:0]  rt,
   input  logic             use_rs,
   input  logic             use_rt,
   input  logic             branch_taken,
   input  logic             ewreg,
   input  logic             em2reg,
   input  logic [RA_W-1:0]  ern,
   input  logic             mwreg,
   input  logic             mm2reg,
   input  logic [RA_W-1:0]  mrn,
   input  logic             mem_req,
   input  logic             mem_ready,
   output logic [1:0]       forwarda,
   output logic [1:0]       forwardb,
   output logic             wpcir,
   output logic             dbubble,
   output logic             freeze,
   output logic             ebubble,
   output logic             mem_err,
   output logic [CNT_W-1:0] stat_lu,
   output logic [CNT_W-1:0] stat_mw,
   output logic [CNT_W-1:0] stat_fl
);

   localparam logic [WAIT_W-1:0] WMAX = WAIT_W'(WAIT_MAX);

   hz_state_t         state;
   hz_state_t         state_nxt;
   logic [WAIT_W-1:0] wait_cnt;
   logic [WAIT_W-1:0] cnt_nxt;
   logic [1:0]        fa;
   logic [1:0]        fb;
   logic              load_use;
   logic              mem_wait;
   logic              wp_int;
   logic              eb_nxt;
   logic              err_set;

   fwd_sel #(.RA_W(RA_W)) u_fwd_a (
      .src     (rs),
      .use_src (use_rs),
      .ewreg   (ewreg),
      .em2reg  (em2reg),
      .ern     (ern),
      .mwreg   (mwreg),
      .mm2reg  (mm2reg),
      .mrn     (mrn),
      .sel     (fa)
   );

   fwd_sel #(.RA_W(RA_W)) u_fwd_b (
      .src     (rt),
      .use_src (use_rt),
      .ewreg   (ewreg),
      .em2reg  (em2reg),
      .ern     (ern),
      .mwreg   (mwreg),
      .mm2reg  (mm2reg),
      .mrn     (mrn),
      .sel     (fb)
   );

   assign load_use = ewreg & em2reg & (ern != '0)
                   & ((use_rs & (ern == rs)) | (use_rt & (ern == rt)));
   assign mem_wait = mem_req & ~mem_ready;

   // a squashed decode slot must not stall on its own operands
   assign wp_int = ~mem_wait & ~(load_use & ~ebubble);
   assign eb_nxt = branch_taken & wp_int & ~ebubble;

   always_comb begin
      freeze   = resetn & mem_wait;
      wpcir    = ~resetn | wp_int;
      dbubble  = ~resetn | (~mem_wait & (ebubble | load_use));
      forwarda = resetn ? fa : FWD_RF;
      forwardb = resetn ? fb : FWD_RF;
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         ebubble <= 1'b0;
      end else if (!mem_wait) begin
         ebubble <= eb_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = wait_cnt;
      unique case (state)
         RUN: begin
            cnt_nxt = '0;
            if (mem_wait) state_nxt = MEM_WAIT;
         end
         MEM_WAIT: begin
            if (wait_cnt != WMAX) cnt_nxt = wait_cnt + 1'b1;
            if (mem_ready) begin
               state_nxt = RUN;
            end else if (wait_cnt == WMAX && mem_wait) begin
               state_nxt = ERR;
            end
         end
         ERR: begin
            if (mem_ready) state_nxt = RUN;
         end
         default: state_nxt = RUN;
      endcase
   end

   // RUN may briefly see a stale saturated count after leaving a wait
   assign err_set = (state != RUN) & (wait_cnt == WMAX) & mem_wait;

   always_ff @(posedge clock) begin
      if (!resetn) begin
         state    <= RUN;
         wait_cnt <= '0;
         mem_err  <= 1'b0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= cnt_nxt;
         if (err_set) mem_err <= 1'b1;
      end
   end

`ifdef HAZ_STATS_EN
   logic [CNT_W-1:0] lu_q;
   logic [CNT_W-1:0] mw_q;
   logic [CNT_W-1:0] fl_q;

   always_ff @(posedge clock) begin
      if (!resetn) begin
         lu_q <= '0;
         mw_q <= '0;
         fl_q <= '0;
      end else begin
         if (load_use && !ebubble && !mem_wait && !(&lu_q)) lu_q <= lu_q + CNT_W'(1);
         if (mem_wait && !(&mw_q)) mw_q <= mw_q + CNT_W'(1);
         if (eb_nxt && !mem_wait && !(&fl_q)) fl_q <= fl_q + CNT_W'(1);
      end
   end

   assign stat_lu = lu_q;
   assign stat_mw = mw_q;
   assign stat_fl = fl_q;
`else
   assign stat_lu = '0;
   assign stat_mw = '0;
   assign stat_fl = '0;
`endif

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Parametrised hazard, forwarding and stall controller for the 5-stage pipelined CPU. It sits beside the decode-stage control unit.
- Computes operand-forward selects for both source operands.
- Detects load-use hazards.
- Freezes the whole pipeline while the data-memory handshake is pending.
- Generates the registered branch-squash bubble internally rather than taking it as an input.
- Adds a memory-wait watchdog.

Parameters:
RA_W, 5, register-address width
WAIT_MAX, 15, maximum consecutive mem-wait cycles before mem_err is raised (1..2^WAIT_W-1)
WAIT_W, 4, watchdog counter width
CNT_W, 16, statistics counter width (used only with the optional feature)

Ports:
clock  in  1  system clock
resetn  in  1  reset; synchronous, active-low
rs  in  RA_W  decode source register A
rt  in  RA_W  decode source register B
use_rs  in  1  decode instruction reads rs
use_rt  in  1  decode instruction reads rt
branch_taken  in  1  decode-stage branch/jump redirect this cycle
ewreg  in  1  EXE stage writes register
em2reg  in  1  EXE stage is a load
ern  in  RA_W  EXE destination
mwreg  in  1  MEM stage writes register
mm2reg  in  1  MEM stage is a load
mrn  in  RA_W  MEM destination
mem_req  in  1  MEM stage holds a load/store
mem_ready  in  1  data memory completes access this cycle
forwarda  out  2  operand A select: 00 regfile, 01 exe_alu, 10 mem_alu, 11 mem_lw
forwardb  out  2  operand B select, same encoding
wpcir  out  1  PC/IF-ID write enable
dbubble  out  1  inject NOP into ID/EXE register
freeze  out  1  hold all pipeline registers
ebubble  out  1  registered: current decode instruction is squashed
mem_err  out  1  sticky watchdog error
stat_lu  out  CNT_W  load-use stall count
stat_mw  out  CNT_W  mem-wait cycle count
stat_fl  out  CNT_W  branch-squash count

Behaviour:
- Forward select, per operand (src = rs or rt, gated by use_*): forwarding applies only when src != 0.
  - Priority 1: ewreg & ~em2reg & ern==src -> 01.
  - Priority 2: mwreg & ~mm2reg & mrn==src -> 10.
  - Priority 3: mwreg & mm2reg & mrn==src -> 11.
  - Otherwise 00.
  - An unused operand always selects 00.
- load_use = ewreg & em2reg & ern!=0 & ((use_rs & ern==rs) | (use_rt & ern==rt)).
- mem_wait = mem_req & ~mem_ready.
- FSM states: RUN, MEM_WAIT, ERR. Reset state is RUN.
  - RUN -> MEM_WAIT when mem_wait.
  - MEM_WAIT -> RUN when mem_ready.
  - MEM_WAIT -> ERR when wait_cnt reaches WAIT_MAX while still waiting.
  - ERR -> RUN when mem_ready; mem_err stays set.
- Combinational outputs:
  - freeze = mem_wait, in any state.
  - wpcir = ~freeze & ~(load_use & ~ebubble).
  - dbubble = ~freeze & (ebubble | load_use).
- A squashed decode instruction (ebubble=1) never causes a load-use stall. Its forward selects are don't-care, but are still computed.
- ebubble register: next value = branch_taken & wpcir & ~ebubble, updated only when ~freeze; holds its value under freeze.
  - A branch resolved during a load-use stall is ignored and re-evaluated next cycle.
  - Back-to-back redirects: the second (squashed) redirect is ignored.
- Watchdog:
  - wait_cnt clears in RUN and increments each MEM_WAIT cycle.
  - Saturates at WAIT_MAX.
  - mem_err is set when wait_cnt==WAIT_MAX & mem_wait; it clears only on reset.
- Simultaneous events: freeze dominates load_use and branch_taken. load_use dominates branch_taken.
- Reset (resetn=0 at a clock edge):
  - ebubble=0, state=RUN, wait_cnt=0, mem_err=0, stat_*=0.
  - While resetn=0, combinational outputs are forced to wpcir=1, dbubble=1, freeze=0, forwarda=forwardb=00.
  - A reset asserted mid-MEM_WAIT aborts the wait.

Optional Feature:
- Macro HAZ_STATS_EN.
- Defined: stat_lu increments on each cycle with load_use & ~ebubble & ~freeze. stat_mw increments on each freeze cycle. stat_fl increments when ebubble is set. All counters saturate at all-ones.
- Undefined: no counter logic is built; stat_* are tied to 0.

Decomposition:
- Package pipe_ctrl_pkg holds:
  - the FWD_RF/FWD_EXE_ALU/FWD_MEM_ALU/FWD_MEM_LW 2-bit constants;
  - the hz_state_t enum (RUN, MEM_WAIT, ERR);
  - the default RA_W.
- Sub-module fwd_sel: one operand's forward-priority logic (src, use, E/M stage fields -> 2-bit select). It is instantiated twice.

Test Plan:
- ern=3 ewreg=1 em2reg=0, rs=3 use_rs=1, rt=3 use_rt=0 -> forwarda=01, forwardb=00, wpcir=1, dbubble=0.
- ern=5 em2reg=1 ewreg=1, rt=5 use_rt=1 -> one cycle with wpcir=0, dbubble=1. Next cycle (load now in MEM, mrn=5 mm2reg=1) -> forwardb=11, wpcir=1.
- mem_req=1, mem_ready=0 for 3 cycles, then 1 -> freeze=1 for exactly 3 cycles, state MEM_WAIT -> RUN, mem_err=0. With HAZ_STATS_EN, stat_mw=3.
- mem_ready held 0 for WAIT_MAX+2 cycles -> mem_err=1 on the cycle wait_cnt hits 15, state ERR. mem_err stays 1 after mem_ready=1; only resetn=0 clears it.
- branch_taken=1 at cycle t -> ebubble=1 and dbubble=1 at t+1. A load_use condition at t+1 does not stall (wpcir=1). branch_taken=1 during a freeze -> ebubble unchanged until freeze drops.
- rs=0 with ern=0 ewreg=1 -> forwarda=00. resetn=0 during a stall -> next cycle ebubble=0, freeze=0, stat_*=0.
